// File: rtl/stack_unit.sv
// LIFO stack with registered pop data, a push+pop swap/bypass path and a sticky
// overflow/underflow error flag. Synchronous active-low reset; storage is not reset.
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              err,
    output logic [ADDR_W:0]   sp_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] SP_ZERO = '0;
    localparam logic [ADDR_W:0] SP_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] SP_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLEAR,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_BYPASS,
        OP_OVERFLOW,
        OP_UNDERFLOW
    } op_e;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W:0]   sp_q, sp_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [ADDR_W:0]   sp_dec;
    logic [ADDR_W-1:0] top_idx;
    logic [DATA_W-1:0] top_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    op_e op;

    assign full   = (sp_q == SP_FULL);
    assign empty  = (sp_q == SP_ZERO);
    assign sp_out = sp_q;
    assign dout   = dout_q;
    assign valid  = valid_q;
    assign err    = err_q;

    assign sp_dec   = sp_q - SP_ONE;
    assign top_idx  = sp_dec[ADDR_W-1:0];
    assign top_word = mem[top_idx];

    // Command decode: clr outranks push/pop; the stack level picks the variant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op = OP_IDLE;
        if (clr) begin
            op = OP_CLEAR;
        end else if (push && pop) begin
            op = empty ? OP_BYPASS : OP_SWAP;
        end else if (push) begin
            op = full ? OP_OVERFLOW : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_UNDERFLOW : OP_POP;
        end
    end

    always_comb begin
        sp_d      = sp_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = sp_q[ADDR_W-1:0];
        mem_wdata = din;

        unique case (op)
            OP_CLEAR: begin
                sp_d = SP_ZERO;
            end
            OP_PUSH: begin
                mem_we = 1'b1;
                sp_d   = sp_q + SP_ONE;
            end
            OP_POP: begin
                dout_d  = top_word;
                sp_d    = sp_dec;
                valid_d = 1'b1;
            end
            OP_SWAP: begin
                // Old top leaves on dout while din replaces it in the same slot.
                dout_d    = top_word;
                mem_we    = 1'b1;
                mem_waddr = top_idx;
                valid_d   = 1'b1;
            end
            OP_BYPASS: begin
                dout_d  = din;
                valid_d = 1'b1;
            end
            OP_OVERFLOW, OP_UNDERFLOW: begin
                err_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!reset) begin
            sp_q    <= SP_ZERO;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the storage array has no reset; the pointer alone defines which words are live.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a queue-based LIFO model checked every cycle,
// plus literal expectations taken from the hand-worked scenarios.
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clr = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              valid, full, empty, err;
    logic [ADDR_W:0]   sp_out;

    stack_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clr(clr), .push(push), .pop(pop), .din(din),
        .dout(dout), .valid(valid), .full(full), .empty(empty), .err(err), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_valid = 1'b0;
    logic              m_err = 1'b0;
    bit                model_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Stack behaviour as a plain LIFO queue, updated once per rising edge.
    task automatic model_update(input logic r, input logic c, input logic pu, input logic po,
                                input logic [DATA_W-1:0] d);
        if (!r) begin
            q.delete();
            m_dout = '0;
            m_valid = 1'b0;
            m_err = 1'b0;
            model_known = 1'b1;
        end else if (c) begin
            q.delete();
            m_valid = 1'b0;
        end else if (pu && po) begin
            if (q.size() == 0) begin
                m_dout = d;
            end else begin
                m_dout = q[q.size()-1];
                q[q.size()-1] = d;
            end
            m_valid = 1'b1;
        end else if (pu) begin
            if (q.size() == DEPTH) m_err = 1'b1;
            else q.push_back(d);
            m_valid = 1'b0;
        end else if (po) begin
            if (q.size() == 0) begin
                m_err = 1'b1;
                m_valid = 1'b0;
            end else begin
                m_dout = q.pop_back();
                m_valid = 1'b1;
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Drives one cycle of inputs, lets the edge happen, and returns 1 ns after it.
    task automatic step(input logic r, input logic c, input logic pu, input logic po,
                        input logic [DATA_W-1:0] d);
        @(negedge clk);
        reset = r;
        clr = c;
        push = pu;
        pop = po;
        din = d;
        @(posedge clk);
        model_update(r, c, pu, po, d);
        #1;
    endtask

    task automatic do_rst();                         step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00); endtask
    task automatic do_push(input logic [7:0] d);     step(1'b1, 1'b0, 1'b1, 1'b0, d);     endtask
    task automatic do_pop();                         step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00); endtask
    task automatic do_swap(input logic [7:0] d);     step(1'b1, 1'b0, 1'b1, 1'b1, d);     endtask
    task automatic do_clr();                         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00); endtask
    task automatic do_idle();                        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00); endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_known) begin
            check("model_sp_out", 32'(sp_out), 32'(q.size()));
            check("model_empty", 32'(empty), 32'(q.size() == 0));
            check("model_full", 32'(full), 32'(q.size() == DEPTH));
            check("model_err", 32'(err), 32'(m_err));
            check("model_valid", 32'(valid), 32'(m_valid));
            check("model_dout", 32'(dout), 32'(m_dout));
        end
    end

    initial begin
        // Reset, then three pushes and three pops.
        do_rst();
        do_rst();
        check("rst_sp", 32'(sp_out), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        do_push(8'h11); check("push1_sp", 32'(sp_out), 32'd1);
        do_push(8'h22); check("push2_sp", 32'(sp_out), 32'd2);
        do_push(8'h33); check("push3_sp", 32'(sp_out), 32'd3);
        do_pop();  check("pop1_dout", 32'(dout), 32'h33); check("pop1_valid", 32'(valid), 32'd1);
        do_pop();  check("pop2_dout", 32'(dout), 32'h22); check("pop2_valid", 32'(valid), 32'd1);
        do_pop();  check("pop3_dout", 32'(dout), 32'h11); check("pop3_valid", 32'(valid), 32'd1);
        do_idle();
        check("idle_valid", 32'(valid), 32'd0);
        check("drained_empty", 32'(empty), 32'd1);
        check("idle_dout_hold", 32'(dout), 32'h11);

        // Fill to capacity, overflow, swap at full, then pop.
        for (int i = 0; i < DEPTH; i++) do_push(8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_sp", 32'(sp_out), 32'd16);
        check("fill_err", 32'(err), 32'd0);
        do_push(8'hAA);
        check("ovf_sp", 32'(sp_out), 32'd16);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_valid", 32'(valid), 32'd0);
        do_swap(8'h55);
        check("swapfull_dout", 32'(dout), 32'h0F);
        check("swapfull_sp", 32'(sp_out), 32'd16);
        do_pop();
        check("popfull_dout", 32'(dout), 32'h55);
        do_pop();
        check("pop_after_ovf", 32'(dout), 32'h0E);

        // Underflow is sticky across clr, cleared only by reset.
        do_rst();
        do_pop();
        check("udf_err", 32'(err), 32'd1);
        check("udf_valid", 32'(valid), 32'd0);
        check("udf_sp", 32'(sp_out), 32'd0);
        do_clr();
        check("clr_keeps_err", 32'(err), 32'd1);
        do_rst();
        check("rst_clears_err", 32'(err), 32'd0);

        // Swap on a non-empty stack.
        do_push(8'h05);
        do_swap(8'h77);
        check("swap_dout", 32'(dout), 32'h05);
        check("swap_valid", 32'(valid), 32'd1);
        check("swap_sp", 32'(sp_out), 32'd1);
        do_pop();
        check("swap_pop_dout", 32'(dout), 32'h77);

        // Bypass on an empty stack.
        do_swap(8'h3C);
        check("byp_dout", 32'(dout), 32'h3C);
        check("byp_valid", 32'(valid), 32'd1);
        check("byp_sp", 32'(sp_out), 32'd0);
        check("byp_err", 32'(err), 32'd0);

        // clr outranks push; reset outranks push.
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h44);
        check("clrpush_sp", 32'(sp_out), 32'd0);
        check("clrpush_empty", 32'(empty), 32'd1);
        check("clrpush_valid", 32'(valid), 32'd0);
        do_push(8'h66);
        check("push_after_clr", 32'(sp_out), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        check("rstpush_sp", 32'(sp_out), 32'd0);
        check("rstpush_dout", 32'(dout), 32'h00);
        do_idle();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
